// File: rtl/lights_pkg.sv
// rtl/lights_pkg.sv - mode encodings, colour range and colour-step helper for the lights sequencer
package lights_pkg;

   typedef enum logic [1:0] {
      WHITE  = 2'b00,
      MANUAL = 2'b01,
      AUTO   = 2'b10,
      PAUSE  = 2'b11
   } mode_t;

   localparam logic [2:0] COL_FIRST = 3'd1;
   localparam logic [2:0] COL_LAST  = 3'd6;

   // Next selector colour; anything at or past the last colour wraps to the first.
   function automatic logic [2:0] next_col(input logic [2:0] col);
      return (col >= COL_LAST) ? COL_FIRST : col + 3'd1;
   endfunction

endpackage

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - 2-flop sync, optional debounce filter (DEBOUNCE_EN), rising-edge pulse
module button_conditioner #(
   parameter int DEB_CYCLES = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic rise
);

   logic sync0;
   logic sync1;
   logic level;
   logic level_prev;

   if (DEB_CYCLES < 2) begin : g_deb_check
      $error("button_conditioner: DEB_CYCLES must be at least 2");
   end

   // Bring the raw asynchronous button into the clock domain.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync0 <= 1'b0;
         sync1 <= 1'b0;
      end else begin
         sync0 <= btn;
         sync1 <= sync0;
      end
   end

`ifdef DEBOUNCE_EN
   localparam int DW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

   logic [DW-1:0] deb_cnt;
   logic          deb_level;

   // Flip the filtered level only after DEB_CYCLES consecutive samples disagree with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         deb_cnt   <= '0;
         deb_level <= 1'b0;
      end else if (sync1 == deb_level) begin
         deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
         deb_level <= sync1;
         deb_cnt   <= '0;
      end else begin
         deb_cnt <= deb_cnt + 1'b1;
      end
   end

   assign level = deb_level;
`else
   assign level = sync1;
`endif

   // One registered pulse per 0->1 transition of the conditioned level.
   always_ff @(posedge clk) begin
      if (rst) begin
         level_prev <= 1'b0;
         rise       <= 1'b0;
      end else begin
         level_prev <= level;
         rise       <= level & ~level_prev;
      end
   end

endmodule

// File: rtl/lights_sequencer.sv
// rtl/lights_sequencer.sv - button-driven sel/step controller with auto-cycle and colour mirror; DEBOUNCE_EN enables button filtering
module lights_sequencer
   import lights_pkg::*;
#(
   parameter int DWELL_CYCLES = 16,
   parameter int DEB_CYCLES   = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_mode,
   input  logic       btn_step,
   output logic       sel,
   output logic       step,
   output logic [1:0] mode,
   output logic [2:0] col_idx
);

   localparam int CW = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DWELL_CYCLES - 1);

   if (DWELL_CYCLES < 2) begin : g_dwell_check
      $error("lights_sequencer: DWELL_CYCLES must be at least 2");
   end

   mode_t         state;
   logic [CW-1:0] cnt;
   logic          mode_rise;
   logic          step_rise;

   button_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_mode_btn (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn_mode),
      .rise (mode_rise)
   );

   button_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_step_btn (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn_step),
      .rise (step_rise)
   );

   // Mode FSM with dwell counter and colour mirror; mode edges always win over step edges.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= WHITE;
         sel     <= 1'b0;
         step    <= 1'b0;
         col_idx <= COL_FIRST;
         cnt     <= '0;
      end else begin
         step <= 1'b0;
         case (state)
            WHITE: begin
               if (mode_rise) begin
                  state <= MANUAL;
                  sel   <= 1'b1;
               end
            end
            MANUAL: begin
               if (mode_rise) begin
                  state <= AUTO;
                  cnt   <= '0;
               end else if (step_rise) begin
                  step    <= 1'b1;
                  col_idx <= next_col(col_idx);
               end
            end
            AUTO: begin
               if (mode_rise) begin
                  state <= WHITE;
                  sel   <= 1'b0;
               end else if (step_rise) begin
                  state <= PAUSE;
               end else if (cnt == CNT_LAST) begin
                  step    <= 1'b1;
                  col_idx <= next_col(col_idx);
                  cnt     <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            PAUSE: begin
               if (mode_rise) begin
                  state <= WHITE;
                  sel   <= 1'b0;
               end else if (step_rise) begin
                  state <= AUTO;
               end
            end
         endcase
      end
   end

   assign mode = state;

endmodule

// File: tb/tb_lights_sequencer.sv
// tb/tb_lights_sequencer.sv - directed vector bench for lights_sequencer (extra filter checks when DEBOUNCE_EN is defined)
module tb_lights_sequencer;
   import lights_pkg::*;

   localparam int DWELL = 4;
   localparam int DEB   = 8;
`ifdef DEBOUNCE_EN
   localparam int LAT = DEB;
`else
   localparam int LAT = 0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_mode;
   logic       btn_step;
   logic       sel;
   logic       step;
   logic [1:0] mode;
   logic [2:0] col_idx;

   int   n_vec  = 0;
   int   n_err  = 0;
   int   pulses = 0;
   logic prev_step = 1'b0;

   typedef struct {
      logic       pm;
      logic       ps;
      int         hold;
      int         settle;
      logic [1:0] emode;
      logic       esel;
      logic [2:0] ecol;
      int         epulse;
   } vec_t;

   vec_t vt[9];

   lights_sequencer #(.DWELL_CYCLES(DWELL), .DEB_CYCLES(DEB)) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_mode (btn_mode),
      .btn_step (btn_step),
      .sel      (sel),
      .step     (step),
      .mode     (mode),
      .col_idx  (col_idx)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Count step pulses and flag any pulse lasting two cycles.
   always @(negedge clk) begin
      if (step === 1'b1) begin
         pulses++;
         chk("step_consecutive", int'(prev_step), 0);
      end
      prev_step = step;
   end

   task automatic apply(input int i);
      pulses   = 0;
      btn_mode = vt[i].pm;
      btn_step = vt[i].ps;
      repeat (vt[i].hold + LAT) tick();
      btn_mode = 1'b0;
      btn_step = 1'b0;
      repeat (vt[i].settle + LAT) tick();
      chk($sformatf("vec%0d_mode", i), mode, vt[i].emode);
      chk($sformatf("vec%0d_sel", i), sel, vt[i].esel);
      chk($sformatf("vec%0d_col", i), col_idx, vt[i].ecol);
      chk($sformatf("vec%0d_pulses", i), pulses, vt[i].epulse);
   endtask

   initial begin
      //          pm    ps    hold settle mode    sel   col   pulses
      vt[0] = '{1'b0, 1'b1,  2,   6, 2'b01, 1'b1, 3'd3, 1};
      vt[1] = '{1'b0, 1'b1,  2,   6, 2'b01, 1'b1, 3'd4, 1};
      vt[2] = '{1'b0, 1'b1,  2,   6, 2'b01, 1'b1, 3'd5, 1};
      vt[3] = '{1'b0, 1'b1,  2,   6, 2'b01, 1'b1, 3'd6, 1};
      vt[4] = '{1'b0, 1'b1,  2,   6, 2'b01, 1'b1, 3'd1, 1};
      vt[5] = '{1'b0, 1'b1,  2,   6, 2'b01, 1'b1, 3'd2, 1};
      vt[6] = '{1'b0, 1'b1, 50,   6, 2'b01, 1'b1, 3'd3, 1};
      vt[7] = '{1'b0, 1'b1,  2,   6, 2'b00, 1'b0, 3'd2, 0};
      vt[8] = '{1'b1, 1'b0,  2,   6, 2'b01, 1'b1, 3'd2, 0};

      // Reset with mode button held and step button chattering.
      rst      = 1'b1;
      btn_mode = 1'b1;
      btn_step = 1'b0;
      tick();
      tick();
      chk("rst_mode", mode, WHITE);
      chk("rst_sel", sel, 0);
      chk("rst_step", step, 0);
      chk("rst_col", col_idx, COL_FIRST);
      for (int t = 0; t < 20; t++) begin
         btn_step = t[0];
         tick();
      end
      chk("rst_hold_mode", mode, WHITE);
      chk("rst_hold_col", col_idx, COL_FIRST);
      btn_step = 1'b0;
      rst      = 1'b0;
      repeat (5 + LAT) tick();
      chk("held_through_rst_mode", mode, MANUAL);
      chk("held_through_rst_sel", sel, 1);
      btn_mode = 1'b0;
      repeat (4 + LAT) tick();

      // Step latency from raw press to pulse.
      btn_step = 1'b1;
      for (int t = 1; t <= 5 + LAT; t++) begin
         tick();
         chk($sformatf("latency_tick%0d", t), step, int'(t == 4 + LAT));
      end
      btn_step = 1'b0;
      repeat (4 + LAT) tick();
      chk("latency_col", col_idx, 2);

      for (int i = 0; i <= 6; i++) apply(i);

`ifdef DEBOUNCE_EN
      // Short glitch is filtered, a long press gives one pulse.
      pulses   = 0;
      btn_step = 1'b1;
      repeat (3) tick();
      btn_step = 1'b0;
      repeat (20) tick();
      chk("glitch_pulses", pulses, 0);
      chk("glitch_col", col_idx, 3);
      pulses   = 0;
      btn_step = 1'b1;
      repeat (10) tick();
      btn_step = 1'b0;
      repeat (20) tick();
      chk("deb_press_pulses", pulses, 1);
      chk("deb_press_col", col_idx, 4);
`else
      // Simultaneous mode+step in MANUAL: enter AUTO, drop the step, then dwell pulses.
      btn_mode = 1'b1;
      btn_step = 1'b1;
      for (int t = 1; t <= 16; t++) begin
         tick();
         if (t == 2) begin
            btn_mode = 1'b0;
            btn_step = 1'b0;
         end
         chk($sformatf("auto_step_tick%0d", t), step, int'(t == 8 || t == 12 || t == 16));
         if (t == 3) chk("simul_mode_before", mode, MANUAL);
         if (t == 4) chk("simul_mode_after", mode, AUTO);
      end
      chk("auto_col", col_idx, 6);

      // Step press in AUTO pauses with counter frozen at its last value.
      btn_step = 1'b1;
      for (int t = 1; t <= 24; t++) begin
         tick();
         if (t == 2) btn_step = 1'b0;
         chk($sformatf("pause_step_tick%0d", t), step, 0);
         if (t == 3) chk("pause_mode_before", mode, AUTO);
         if (t == 4) chk("pause_mode_after", mode, PAUSE);
      end
      chk("pause_sel", sel, 1);
      chk("pause_col", col_idx, 6);

      // Resume: one remaining dwell cycle, then the normal period.
      btn_step = 1'b1;
      for (int t = 1; t <= 9; t++) begin
         tick();
         if (t == 2) btn_step = 1'b0;
         chk($sformatf("resume_step_tick%0d", t), step, int'(t == 5 || t == 9));
         if (t == 4) chk("resume_mode", mode, AUTO);
      end
      chk("resume_col_wrap", col_idx, 2);

      // Mode press in AUTO returns to WHITE ahead of a due dwell step.
      btn_mode = 1'b1;
      for (int t = 1; t <= 8; t++) begin
         tick();
         if (t == 2) btn_mode = 1'b0;
         chk($sformatf("to_white_step_tick%0d", t), step, 0);
         if (t == 4) begin
            chk("to_white_mode", mode, WHITE);
            chk("to_white_sel", sel, 0);
         end
      end
      chk("to_white_col", col_idx, 2);

      for (int i = 7; i <= 8; i++) apply(i);
`endif

      // Reset in the middle of operation.
      rst = 1'b1;
      tick();
      tick();
      chk("midrst_mode", mode, WHITE);
      chk("midrst_sel", sel, 0);
      chk("midrst_step", step, 0);
      chk("midrst_col", col_idx, COL_FIRST);
      rst = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
